div_ctrl: RTL



---
 rtl/div_ctrl_pkg.sv | 14 +
 rtl/div_ctrl_if.sv | 23 ++
 rtl/div_ctrl_step.sv | 24 ++
 rtl/div_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider controller.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // Divide-by-zero quotient; sliced down to the operand width at the use site.
  localparam int unsigned        DIV_MAX_W   = 64;
  localparam logic [DIV_MAX_W-1:0] DIV_DBZ_QUO = '1;

endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage divide request/result bundle between pipeline and divider.
interface div_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               annul_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_i, a_i, b_i, annul_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, annul_i,
    output stall_o, ready_o, result_o
  );
endinterface

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  import div_ctrl_pkg::*;

  logic [WIDTH:0] shifted;
  logic           take;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    take    = shifted >= {1'b0, div_i};
    // rem < div on entry, so the difference always fits back in WIDTH bits
    rem_o   = take ? WIDTH'(shifted - {1'b0, div_i}) : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], take};
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: drives the E-stage stall and presents {HI, LO}.
module div_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);
  import div_ctrl_pkg::*;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] rem_fix, quo_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    a_neg = bus.signed_i & bus.a_i[WIDTH-1];
    b_neg = bus.signed_i & bus.b_i[WIDTH-1];
    a_abs = a_neg ? ('0 - bus.a_i) : bus.a_i;
    b_abs = b_neg ? ('0 - bus.b_i) : bus.b_i;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;

    if (bus.annul_i) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (bus.start_i) begin
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            dvs_d  = b_abs;
            cnt_d  = '0;
            if (bus.b_i == '0) begin
              rem_d   = bus.a_i;
              quo_d   = DIV_DBZ_QUO[WIDTH-1:0];
              dbz_d   = 1'b1;
              state_d = DIV_DONE;
            end else begin
              rem_d   = '0;
              quo_d   = a_abs;
              dbz_d   = 1'b0;
              state_d = DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DIV_DONE;
          end
        end
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
    end
  end

  // Sign fix-up stays combinational on the held registers, so result_o is
  // stable between operations and reads as zero straight out of reset.
  always_comb begin
    rem_fix = rneg_q ? ('0 - rem_q) : rem_q;
    quo_fix = qneg_q ? ('0 - quo_q) : quo_q;
  end

  // rst gating keeps the stall low while reset is held with start_i high.
  assign bus.stall_o  = ~rst & ~bus.annul_i &
                        (((state_q == DIV_IDLE) & bus.start_i) | (state_q == DIV_BUSY));
  assign bus.ready_o  = (state_q == DIV_DONE) & ~bus.annul_i;
  assign bus.result_o = dbz_q ? {rem_q, quo_q} : {rem_fix, quo_fix};

endmodule
